// File: rtl/spike_filter_bank.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | spike_filter_bank: bank of leaky spike-count integrators sharing one     |
// | multiply datapath; increments on demand, decays in a handshaked sweep.   |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module spike_filter_bank #(
  parameter int NFILTS = 16,
  parameter int NSTATE = 27,
  parameter int NCT    = 10,
  parameter int NMODES = 4,
  localparam int MW = (NMODES > 1) ? $clog2(NMODES) : 1,
  localparam int FW = $clog2(NFILTS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FW-1:0]            in_tag,
  input  logic [NCT-1:0]           in_ct,
  input  logic                     in_v,
  output logic                     in_a,
  output logic [NSTATE-1:0]        out_state,
  output logic [FW-1:0]            out_filt,
  output logic                     out_v,
  input  logic                     out_r,
  input  logic                     update_pulse,
  input  logic [FW:0]              filts_used,
  input  logic [NMODES*NSTATE-1:0] inc_const,
  input  logic [NMODES*NSTATE-1:0] decay_const,
  input  logic                     cfg_we,
  input  logic [FW-1:0]            cfg_filt,
  input  logic [MW-1:0]            cfg_mode,
  output logic                     sat_flag,
  output logic                     overrun
);

  localparam logic [2:0] S_CLEAR     = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_INC_RD    = 3'd2;
  localparam logic [2:0] S_INC_WR    = 3'd3;
  localparam logic [2:0] S_UPD_FIRST = 3'd4;
  localparam logic [2:0] S_UPD       = 3'd5;
  localparam logic [2:0] S_UPD_LAST  = 3'd6;

  localparam logic [FW:0] IDX_ONE = {{FW{1'b0}}, 1'b1};

  logic [2:0]          r_state;
  logic [NSTATE-1:0]   r_mem  [NFILTS];
  logic [MW-1:0]       r_mode [NFILTS];
  logic [NSTATE-1:0]   r_rd_data;
  logic [FW-1:0]       r_rd_filt;
  logic [MW-1:0]       r_rd_mode;
  logic [FW:0]         r_idx;
  logic [FW-1:0]       r_tag;
  logic [NCT-1:0]      r_ct;
  logic                r_pending;
  logic                r_sat;
  logic                r_overrun;

  logic [NSTATE-1:0]     w_inc_k;
  logic [NSTATE-1:0]     w_dec_k;
  logic [NSTATE+NCT-1:0] w_inc_prod;
  logic [NSTATE:0]       w_inc_sum;
  logic                  w_inc_sat;
  logic [NSTATE-1:0]     w_inc_res;
  logic [2*NSTATE-1:0]   w_dec_prod;
  logic [NSTATE-1:0]     w_decayed;
  logic                  w_xfer;
  logic                  w_tag_ok;
  logic                  w_take_upd;
  logic                  w_last_rd;
  logic                  w_we;
  logic [FW-1:0]         w_waddr;
  logic [NSTATE-1:0]     w_wdata;
  logic                  w_re;
  logic [FW-1:0]         w_raddr;
  logic                  w_unused;

  // Mode is captured with the read data, so a stalled output stays stable even if cfg_we hits that filter.
  always_comb begin
    w_inc_k    = inc_const[int'(r_rd_mode)*NSTATE +: NSTATE];
    w_dec_k    = decay_const[int'(r_rd_mode)*NSTATE +: NSTATE];
    w_inc_prod = {{NCT{1'b0}}, w_inc_k} * {{NSTATE{1'b0}}, r_ct};
    w_inc_sum  = {1'b0, r_rd_data} + {1'b0, w_inc_prod[NSTATE-1:0]};
    w_inc_sat  = w_inc_sum[NSTATE] | (|w_inc_prod[NSTATE+NCT-1:NSTATE]);
    w_inc_res  = w_inc_sat ? {NSTATE{1'b1}} : w_inc_sum[NSTATE-1:0];
    w_dec_prod = {{NSTATE{1'b0}}, w_dec_k} * {{NSTATE{1'b0}}, r_rd_data};
    w_decayed  = w_dec_prod[2*NSTATE-1:NSTATE];
    w_unused   = ^w_dec_prod[NSTATE-1:0];
  end

  assign out_v      = (r_state == S_UPD) || (r_state == S_UPD_LAST);
  assign in_a       = (r_state == S_INC_WR);
  assign out_state  = w_decayed;
  assign out_filt   = r_rd_filt;
  assign sat_flag   = r_sat;
  assign overrun    = r_overrun;
  assign w_xfer     = out_v & out_r;
  assign w_tag_ok   = ({1'b0, r_tag} < filts_used);
  assign w_take_upd = (r_state == S_IDLE) && !in_v && r_pending;
  assign w_last_rd  = (r_idx == (filts_used - IDX_ONE));

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_rd_filt;
    w_wdata = w_decayed;
    w_re    = 1'b0;
    w_raddr = r_tag;
    case (r_state)
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_idx[FW-1:0];
        w_wdata = '0;
      end
      S_INC_RD:    w_re = 1'b1;
      S_INC_WR: begin
        w_we    = w_tag_ok;
        w_waddr = r_tag;
        w_wdata = w_inc_res;
      end
      S_UPD_FIRST: begin
        w_re    = 1'b1;
        w_raddr = '0;
      end
      S_UPD: begin
        w_we    = w_xfer;
        w_re    = w_xfer;
        w_raddr = r_idx[FW-1:0];
      end
      S_UPD_LAST:  w_we = w_xfer;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    if (w_re) begin
      r_rd_data <= r_mem[w_raddr];
      r_rd_filt <= w_raddr;
      r_rd_mode <= r_mode[w_raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NFILTS; k++) r_mode[k] <= '0;
    end else if (cfg_we) begin
      r_mode[cfg_filt] <= cfg_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_idx     <= '0;
      r_tag     <= '0;
      r_ct      <= '0;
      r_pending <= 1'b0;
      r_sat     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // A pulse landing on the cycle the sweep is launched re-arms rather than overruns.
      if (update_pulse) begin
        if (r_pending && !w_take_upd) r_overrun <= 1'b1;
        r_pending <= 1'b1;
      end else if (w_take_upd) begin
        r_pending <= 1'b0;
      end
      if ((r_state == S_INC_WR) && w_tag_ok && w_inc_sat) r_sat <= 1'b1;

      case (r_state)
        S_CLEAR: begin
          r_idx <= r_idx + IDX_ONE;
          if (&r_idx[FW-1:0]) begin
            r_idx   <= '0;
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (in_v) begin
            r_tag   <= in_tag;
            r_ct    <= in_ct;
            r_state <= S_INC_RD;
          end else if (r_pending) begin
            r_idx   <= '0;
            r_state <= S_UPD_FIRST;
          end
        end
        S_INC_RD: r_state <= S_INC_WR;
        S_INC_WR: r_state <= S_IDLE;
        S_UPD_FIRST: begin
          r_idx   <= IDX_ONE;
          r_state <= (filts_used == IDX_ONE) ? S_UPD_LAST : S_UPD;
        end
        S_UPD: begin
          if (w_xfer) begin
            r_idx <= r_idx + IDX_ONE;
            if (w_last_rd) r_state <= S_UPD_LAST;
          end
        end
        S_UPD_LAST: if (w_xfer) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spike_filter_bank.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_spike_filter_bank: directed and random checks of spike_filter_bank    |
// | against an arithmetic reference model of filter state and flags.         |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module tb_spike_filter_bank;
  localparam int NF = 16;
  localparam int NS = 27;
  localparam int NC = 10;
  localparam int NM = 4;
  localparam int FW = 4;
  localparam int MW = 2;

  logic clk = 1'b0;
  logic reset, in_v, in_a, out_v, out_r, update_pulse, cfg_we, sat_flag, overrun;
  logic [FW-1:0] in_tag, out_filt, cfg_filt;
  logic [NC-1:0] in_ct;
  logic [NS-1:0] out_state;
  logic [FW:0]   filts_used;
  logic [NM*NS-1:0] inc_const, decay_const;
  logic [MW-1:0] cfg_mode;

  always #5 clk = ~clk;

  spike_filter_bank #(.NFILTS(NF), .NSTATE(NS), .NCT(NC), .NMODES(NM)) dut (
    .clk(clk), .reset(reset), .in_tag(in_tag), .in_ct(in_ct), .in_v(in_v), .in_a(in_a),
    .out_state(out_state), .out_filt(out_filt), .out_v(out_v), .out_r(out_r),
    .update_pulse(update_pulse), .filts_used(filts_used), .inc_const(inc_const),
    .decay_const(decay_const), .cfg_we(cfg_we), .cfg_filt(cfg_filt), .cfg_mode(cfg_mode),
    .sat_flag(sat_flag), .overrun(overrun)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [NS-1:0] m_mem [NF];
  int  m_mode [NF];
  bit  m_sat, m_ovr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [NS-1:0] k_of(input logic [NM*NS-1:0] v, input int m);
    return v[m*NS +: NS];
  endfunction

  // Fractional multiply: d is a 0.NS fraction, result floors toward zero.
  function automatic logic [NS-1:0] ref_decay(input logic [NS-1:0] s, input logic [NS-1:0] d);
    logic [63:0] p;
    p = (64'(d) * 64'(s)) >> NS;
    return p[NS-1:0];
  endfunction

  function automatic logic [NS:0] ref_inc(input logic [NS-1:0] s, input logic [NS-1:0] k, input int ct);
    logic [63:0] prod, sum, lim;
    lim  = (64'd1 << NS) - 64'd1;
    prod = 64'(k) * 64'(ct);
    sum  = 64'(s) + (prod & lim);
    if ((prod >> NS) != 0 || sum > lim) return {1'b1, lim[NS-1:0]};
    return {1'b0, sum[NS-1:0]};
  endfunction

  task automatic do_inc(input int tag, input int ct, input bit with_pulse);
    int n;
    logic [NS:0] r;
    @(negedge clk);
    in_v = 1'b1; in_tag = FW'(tag); in_ct = NC'(ct); update_pulse = with_pulse;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      update_pulse = 1'b0;
    end while (in_a !== 1'b1 && n < 50);
    check("inc_in_a_latency", n, 2);
    if (tag < int'(filts_used)) begin
      r = ref_inc(m_mem[tag], k_of(inc_const, m_mode[tag]), ct);
      m_mem[tag] = r[NS-1:0];
      if (r[NS]) m_sat = 1'b1;
    end
    @(negedge clk);
    in_v = 1'b0;
    @(posedge clk); #1;
    check("inc_in_a_single", in_a, 0);
  endtask

  task automatic set_mode(input int f, input int m);
    @(negedge clk);
    cfg_we = 1'b1; cfg_filt = FW'(f); cfg_mode = MW'(m);
    @(negedge clk);
    cfg_we = 1'b0;
    m_mode[f] = m;
  endtask

  task automatic run_sweep(input bit pulse, input int stall_at, input int stall_len,
                           input int extra, input int pin_f, input logic [NS-1:0] pin_v);
    int i, ncyc, stalled, first, last;
    bit bad_ina;
    logic [NS-1:0] e;
    @(negedge clk);
    update_pulse = pulse; out_r = 1'b1;
    i = 0; ncyc = 0; stalled = 0; first = -1; last = 0; bad_ina = 0;
    while (i < int'(filts_used) && ncyc < 300) begin
      @(negedge clk);
      ncyc++;
      update_pulse = 1'b0;
      if (in_a !== 1'b0) bad_ina = 1;
      if (out_v === 1'b1) begin
        if (first < 0) first = ncyc;
        e = ref_decay(m_mem[i], k_of(decay_const, m_mode[i]));
        check("sweep_filt", out_filt, i);
        check("sweep_state", out_state, e);
        if (i == pin_f) check("sweep_pinned", out_state, pin_v);
        if (i == stall_at && stalled < stall_len) begin
          out_r = 1'b0;
          stalled++;
        end else begin
          out_r = 1'b1;
          m_mem[i] = e;
          if (i >= 1 && i <= extra) update_pulse = 1'b1;
          i++;
          last = ncyc;
        end
      end else begin
        out_r = 1'b1;
      end
    end
    check("sweep_done", i, filts_used);
    check("sweep_span", last - first + 1, int'(filts_used) + stalled);
    check("sweep_in_a_low", bad_ina, 0);
    @(negedge clk);
    update_pulse = 1'b0; out_r = 1'b1;
    check("sweep_end_out_v", out_v, 0);
    if (extra >= 2) m_ovr = 1'b1;
  endtask

  initial begin
    bit bad;
    reset = 1'b1; in_v = 1'b0; in_tag = '0; in_ct = '0; out_r = 1'b1; update_pulse = 1'b0;
    cfg_we = 1'b0; cfg_filt = '0; cfg_mode = '0; filts_used = 5'd8;
    inc_const = '0; decay_const = '0;
    for (int k = 0; k < NF; k++) begin m_mem[k] = '0; m_mode[k] = 0; end
    m_sat = 1'b0; m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_a", in_a, 0);
    check("rst_out_v", out_v, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    bad = 0;
    repeat (NF) begin
      @(negedge clk);
      if (in_a !== 1'b0 || out_v !== 1'b0) bad = 1;
    end
    check("clear_quiet", bad, 0);
    repeat (2) @(negedge clk);

    inc_const[0 +: NS]   = 27'h200;
    decay_const[0 +: NS] = 27'h4000000;
    do_inc(5, 3, 0);
    run_sweep(1, -1, 0, 0, 5, 27'h300);

    do_inc(3, 7, 0);
    run_sweep(1, 3, 3, 0, -1, '0);
    run_sweep(1, -1, 0, 0, -1, '0);

    inc_const[0 +: NS] = 27'h3FFFFFF;
    do_inc(6, 2, 0);
    check("sat_not_yet", sat_flag, 0);
    inc_const[0 +: NS] = 27'h200;
    do_inc(6, 2, 0);
    check("sat_set", sat_flag, 1);
    run_sweep(1, -1, 0, 0, 6, 27'h3FFFFFF);

    check("overrun_clear", overrun, 0);
    run_sweep(1, -1, 0, 3, -1, '0);
    check("overrun_set", overrun, 1);
    run_sweep(0, -1, 0, 0, -1, '0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_v !== 1'b0) bad = 1;
    end
    check("no_third_sweep", bad, 0);

    decay_const[NS +: NS] = 27'h2000000;
    inc_const[NS +: NS]   = 27'h200;
    set_mode(2, 1);
    do_inc(2, 2, 0);
    run_sweep(1, -1, 0, 0, 2, 27'h100);

    do_inc(4, 1, 1);
    run_sweep(0, -1, 0, 0, -1, '0);

    filts_used = 5'd16;
    do_inc(12, 4, 0);
    filts_used = 5'd8;
    do_inc(12, 5, 0);
    filts_used = 5'd16;
    run_sweep(1, -1, 0, 0, 12, 27'h400);

    filts_used = 5'd1;
    run_sweep(1, -1, 0, 0, -1, '0);
    filts_used = 5'd16;

    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      for (int m = 0; m < NM; m++) begin
        inc_const[m*NS +: NS]   = NS'($urandom) >> $urandom_range(0, 20);
        decay_const[m*NS +: NS] = NS'($urandom);
      end
      for (int j = 0; j < 3; j++) set_mode($urandom_range(0, NF-1), $urandom_range(0, NM-1));
      for (int j = 0; j < 6; j++) do_inc($urandom_range(0, NF-1), $urandom_range(0, 1023), 0);
      check("rand_sat", sat_flag, m_sat);
      run_sweep(1, $urandom_range(0, NF-1), $urandom_range(0, 3), 0, -1, '0);
    end

    check("final_sat", sat_flag, m_sat);
    check("final_overrun", overrun, m_ovr);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/spike_filter_bank.md
SPIKE_FILTER_BANK -- requirements
Module: spike_filter_bank

Interface
REQ-001 SHALL have parameter NFILTS, default 16, number of filters (power of two, >=2).
REQ-002 SHALL have parameter NSTATE, default 27, filter state width, unsigned fixed point 18.9.
REQ-003 SHALL have parameter NCT, default 10, spike count width.
REQ-004 SHALL have parameter NMODES, default 4, number of time-constant sets (>=1); MW = max(1, clog2(NMODES)), FW = clog2(NFILTS).
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-006 SHALL have the following ports: in_tag  in  FW  filter index of arriving spike count; in_ct  in  NCT  spike count; in_v  in  1  input valid; in_a  out  1  input accept.
REQ-007 SHALL have the following ports: out_state  out  NSTATE  decayed filter state; out_filt  out  FW  filter index; out_v  out  1  output valid; out_r  in  1  output ready.
REQ-008 SHALL have the following ports: update_pulse  in  1  start decay sweep; filts_used  in  FW+1  filters swept, 1..NFILTS.
REQ-009 SHALL have the following ports: inc_const  in  NMODES*NSTATE  per-mode increment, 18.9; decay_const  in  NMODES*NSTATE  per-mode multiplier, 0.NSTATE; mode set k occupies bits [k*NSTATE +: NSTATE].
REQ-010 SHALL have the following ports: cfg_we  in  1  mode-table write; cfg_filt  in  FW  filter to configure; cfg_mode  in  MW  mode index.
REQ-011 SHALL have the following ports: sat_flag  out  1  sticky, set when any saturation has occurred; overrun  out  1  sticky, set when update_pulse was lost.

Function
REQ-012 SHALL store NFILTS states in a memory with a 1-cycle synchronous read and an independent write port, plus an NFILTS x MW mode table.
REQ-013 SHALL implement states IDLE, INC_RD, INC_WR, UPD_FIRST, UPD, UPD_LAST.
REQ-014 SHALL, in IDLE with in_v=1, latch in_tag/in_ct and go to INC_RD; an input has priority over a pending or new update request.
REQ-015 SHALL, in INC_RD, read state[tag], then go to INC_WR.
REQ-016 SHALL, in INC_WR, write sat(state + (inc_const[mode[tag]]*ct)[NSTATE-1:0]) to state[tag], assert in_a for exactly this cycle, and return to IDLE.
REQ-017 SHALL saturate the increment sum to all-ones when it overflows NSTATE bits, or when the discarded product MSBs are non-zero, and set sat_flag in the same cycle.
REQ-018 SHALL register update_pulse into a one-deep pending flag; a pulse arriving while pending is already set SHALL set overrun.
REQ-019 SHALL, in IDLE with in_v=0 and pending=1, clear pending, set the index to 0, and go to UPD_FIRST.
REQ-020 SHALL, in UPD_FIRST, read filter 0 and go to UPD (or to UPD_LAST when filts_used=1).
REQ-021 SHALL compute decayed = (decay_const[mode[i]] * state[i]) >> NSTATE, truncating.
REQ-022 SHALL, in UPD, write decayed to filter i-1 and present it on out_state/out_filt with out_v=1, while reading filter i.
REQ-023 SHALL advance the sweep only on out_v & out_r; while out_r=0 the block SHALL hold out_* stable, perform no write, and not advance the read index.
REQ-024 SHALL leave UPD for UPD_LAST after the transfer in which filter filts_used-1 was read.
REQ-025 SHALL, in UPD_LAST, present and write the last filter and return to IDLE on out_r=1; in_a SHALL stay 0 throughout a sweep.
REQ-026 SHALL, on cfg_we=1, write the mode table in the same cycle; the new mode takes effect on the next access to that filter, and an access in the same cycle uses the old mode.
REQ-027 SHALL, when in_tag >= filts_used, accept the input through INC_WR with no memory write.
REQ-028 SHALL hold out_v=0 outside UPD and UPD_LAST.

Reset
REQ-029 SHALL, on reset, set state=IDLE, pending=0, in_a=0, out_v=0, sat_flag=0, overrun=0, and set every mode-table entry to 0; reset mid-sweep SHALL abort the sweep, leaving states partially decayed.
REQ-030 SHALL clear the state memory by a sweep after reset: the block SHALL write 0 to all NFILTS entries in NFILTS cycles with in_a=0, and only then enter IDLE.

Verification
REQ-031 SHALL be verified by: reset, inc_const[0]=0x200 (1.0), ct=3, tag=5 -> state[5]=0x600; in_a high exactly 2 cycles after acceptance in IDLE.
REQ-032 SHALL be verified by: state[5]=0x600, decay_const[0]=0x4000000 (0.5), filts_used=8, pulse, out_r=1 -> 8 outputs of filt 0..7 on consecutive cycles; filt 5 outputs 0x300.
REQ-033 SHALL be verified by: out_r low for 3 cycles during filt 3 -> out_state/out_filt held stable; final memory identical to the no-stall run.
REQ-034 SHALL be verified by: state=0x7FFFFFE, inc_const=0x200, ct=2 -> result 0x7FFFFFF and sat_flag=1.
REQ-035 SHALL be verified by: three pulses during one sweep -> one extra sweep runs and overrun=1; filter 2 set to mode 1 with decay 0.25 -> 0x400 decays to 0x100.
REQ-036 SHALL be verified by: in_v held high together with a pulse in IDLE -> the increment completes first and the sweep starts next; tag=12 with filts_used=8 -> in_a asserted and memory unchanged.
